abc_field_source: RTL and testbench

- Byte-stream to parallel-field assembler that drives the d1/d2/d3 bus consumed by module-level sinks of the g_w1/g_w2/g_w3 family.
- Accepts a byte-wide valid/ready stream framed by a last flag.
- Unpacks each frame little-endian into the three fields.
- Presents the fields on a registered valid/ready output held stable until consumed; malformed frames are dropped and flagged.

---
 rtl/abc_field_source.sv | 145 ++++++++++++++
 tb/tb_abc_field_source.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abc_field_source.sv
// Byte-stream to d1/d2/d3 field assembler: little-endian unpack of fixed-length frames,
// registered valid/ready output, malformed frames dropped with a one-cycle err pulse.
`timescale 1ns/1ps
module abc_field_source #(
   parameter int g_w1 = 8,
   parameter int g_w2 = 32,
   parameter int g_w3 = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [g_w1-1:0]     d1,
   output logic [g_w2+1:0]     d2,
   output logic [g_w3*2-1:0]   d3,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                err
);

   localparam int W1 = g_w1;
   localparam int W2 = g_w2 + 2;
   localparam int W3 = g_w3 * 2;
   localparam int B1 = (W1 + 7) / 8;
   localparam int B2 = (W2 + 7) / 8;
   localparam int B3 = (W3 + 7) / 8;
   localparam int NB = B1 + B2 + B3;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic [2:0] {S_D1, S_D2, S_D3, S_HOLD, S_SKIP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [W1-1:0]   sh1, sh1_n;
   logic [W2-1:0]   sh2, sh2_n;
   logic [W3-1:0]   sh3, sh3_n;
   logic            acc, load, err_n;

   assign in_ready = !rst && (state != S_HOLD);
   assign acc      = in_valid && in_ready;

   // Shadow update includes the byte being accepted this cycle, so the final
   // byte of d3 can be loaded into the outputs on the same edge.
   always_comb begin
      sh1_n = sh1;
      sh2_n = sh2;
      sh3_n = sh3;
      if (acc && state == S_D1)
         for (int b = 0; b < W1; b++)
            if (cnt == CW'(b / 8)) sh1_n[b] = in_data[3'(b % 8)];
      if (acc && state == S_D2)
         for (int b = 0; b < W2; b++)
            if (cnt == CW'(b / 8)) sh2_n[b] = in_data[3'(b % 8)];
      if (acc && state == S_D3)
         for (int b = 0; b < W3; b++)
            if (cnt == CW'(b / 8)) sh3_n[b] = in_data[3'(b % 8)];
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = 1'b0;
      load    = 1'b0;
      unique case (state)
         S_D1: if (acc) begin
            if (in_last) begin
               err_n = 1'b1;
               cnt_n = '0;
            end else if (cnt == CW'(B1 - 1)) begin
               state_n = S_D2;
               cnt_n   = '0;
            end else
               cnt_n = cnt + 1'b1;
         end
         S_D2: if (acc) begin
            if (in_last) begin
               state_n = S_D1;
               err_n   = 1'b1;
               cnt_n   = '0;
            end else if (cnt == CW'(B2 - 1)) begin
               state_n = S_D3;
               cnt_n   = '0;
            end else
               cnt_n = cnt + 1'b1;
         end
         S_D3: if (acc) begin
            cnt_n = '0;
            if (cnt == CW'(B3 - 1)) begin
               if (in_last) begin
                  state_n = S_HOLD;
                  load    = 1'b1;
               end else begin
                  state_n = S_SKIP;
                  err_n   = 1'b1;
               end
            end else if (in_last) begin
               state_n = S_D1;
               err_n   = 1'b1;
            end else
               cnt_n = cnt + 1'b1;
         end
         S_HOLD: if (out_ready) state_n = S_D1;
         // Overlong tail: drain to the frame delimiter without further err.
         S_SKIP: if (acc && in_last) state_n = S_D1;
         default: state_n = S_D1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_D1;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh1       <= '0;
         sh2       <= '0;
         sh3       <= '0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         sh1       <= sh1_n;
         sh2       <= sh2_n;
         sh3       <= sh3_n;
         err       <= err_n;
         out_valid <= (state_n == S_HOLD);
         if (load) begin
            d1 <= sh1_n;
            d2 <= sh2_n;
            d3 <= sh3_n;
         end
      end
   end

endmodule

// File: tb/tb_abc_field_source.sv
// Bench for abc_field_source: directed scenarios plus a randomized frame stream
// scored against a per-frame little-endian unpacking model.
`timescale 1ns/1ps
module tb_abc_field_source;

   localparam int W1 = 8;
   localparam int W2 = 34;
   localparam int W3 = 32;
   localparam int B1 = 1;
   localparam int B2 = 5;
   localparam int B3 = 4;
   localparam int NB = B1 + B2 + B3;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [W1-1:0] a;
      logic [W2-1:0] b;
      logic [W3-1:0] c;
   } fr_t;

   logic            clk, rst;
   logic [7:0]      in_data;
   logic            in_valid, in_last, in_ready;
   logic [W1-1:0]   d1;
   logic [W2-1:0]   d2;
   logic [W3-1:0]   d3;
   logic            out_valid, out_ready, err;

   int checks = 0;
   int failures = 0;

   abc_field_source #(.g_w1(8), .g_w2(32), .g_w3(16)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .d1(d1), .d2(d2), .d3(d3),
      .out_valid(out_valid), .out_ready(out_ready), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame model: fields are consecutive little-endian byte groups, truncated to width.
   function automatic fr_t model(input bq_t f);
      fr_t r;
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < B1; k++) v = v | (64'(f[k]) << (8 * k));
      r.a = v[W1-1:0];
      v = '0;
      for (int k = 0; k < B2; k++) v = v | (64'(f[B1 + k]) << (8 * k));
      r.b = v[W2-1:0];
      v = '0;
      for (int k = 0; k < B3; k++) v = v | (64'(f[B1 + B2 + k]) << (8 * k));
      r.c = v[W3-1:0];
      return r;
   endfunction

   function automatic bq_t rand_frame(input int len);
      bq_t f;
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      return f;
   endfunction

   // Returns at posedge+1 after the byte has been accepted.
   task automatic put_byte(input logic [7:0] b, input logic last);
      int n;
      n = 0;
      in_data = b; in_last = last; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL put_byte_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
         if (failures > 40) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "aborting after repeated stalls");
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_frame(input bq_t f, input bit gaps);
      for (int i = 0; i < f.size(); i++) begin
         if (gaps && ($urandom % 2 == 1)) begin
            in_valid = 1'b0; in_last = 1'($urandom); in_data = 8'($urandom);
            @(posedge clk); #1;
         end
         put_byte(f[i], i == f.size() - 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: out_valid=%0b err=%0b in_ready=%0b, required 0 0 0", out_valid, err, in_ready);
      end
      checks++;
      if (d1 !== '0 || d2 !== '0 || d3 !== '0) begin
         failures++;
         $display("FAIL reset_data: d1=%h d2=%h d3=%h, required all 0", d1, d2, d3);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bq_t f;
      f = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
      out_ready = 1'b1;
      send_frame(f, 0);
      checks++;
      if (out_valid !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL basic_valid: out_valid=%0b err=%0b, required 1 0", out_valid, err);
      end
      checks++;
      if (d1 !== 8'h5A || d2 !== 34'h3_0403_0201 || d3 !== 32'h4433_2211) begin
         failures++;
         $display("FAIL basic_data: d1=%h d2=%h d3=%h, required 5a 304030201 44332211", d1, d2, d3);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_one_cycle: out_valid=%0b, required 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      bq_t f, g;
      fr_t e;
      f = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
      g = rand_frame(NB);
      out_ready = 1'b0;
      send_frame(f, 0);
      in_data = g[0]; in_valid = 1'b1; in_last = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || d1 !== 8'h5A ||
             d2 !== 34'h3_0403_0201 || d3 !== 32'h4433_2211) begin
            failures++;
            $display("FAIL bp_hold cyc%0d: in_ready=%0b out_valid=%0b d1=%h d2=%h d3=%h, required 0 1 5a 304030201 44332211",
                     i, in_ready, out_valid, d1, d2, d3);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: out_valid=%0b, required 0", out_valid);
      end
      send_frame(g, 0);
      e = model(g);
      checks++;
      if (out_valid !== 1'b1 || {d1, d2, d3} !== e) begin
         failures++;
         $display("FAIL bp_second: out_valid=%0b data=%h, required 1 %h", out_valid, {d1, d2, d3}, e);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_short();
      bq_t f, g;
      fr_t e;
      out_ready = 1'b1;
      f = rand_frame(4);
      send_frame(f, 0);
      checks++;
      if (err !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL short_err: err=%0b out_valid=%0b, required 1 0", err, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL short_pulse: err=%0b out_valid=%0b, required 0 0", err, out_valid);
      end
      g = rand_frame(NB);
      e = model(g);
      send_frame(g, 0);
      checks++;
      if (out_valid !== 1'b1 || {d1, d2, d3} !== e) begin
         failures++;
         $display("FAIL short_next: out_valid=%0b data=%h, required 1 %h", out_valid, {d1, d2, d3}, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_long();
      bq_t f, g;
      fr_t e;
      out_ready = 1'b1;
      f = rand_frame(NB + 2);
      for (int i = 0; i < f.size(); i++) begin
         put_byte(f[i], i == f.size() - 1);
         checks++;
         if (err !== (i == NB - 1) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL long_byte%0d: err=%0b out_valid=%0b, required %0b 0", i + 1, err, out_valid, (i == NB - 1));
         end
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL long_no_second_err: err=%0b, required 0", err);
      end
      g = rand_frame(NB);
      e = model(g);
      send_frame(g, 0);
      checks++;
      if (out_valid !== 1'b1 || {d1, d2, d3} !== e) begin
         failures++;
         $display("FAIL long_next: out_valid=%0b data=%h, required 1 %h", out_valid, {d1, d2, d3}, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bq_t f;
      fr_t e;
      out_ready = 1'b0;
      f = rand_frame(NB);
      for (int i = 0; i < 6; i++) put_byte(f[i], 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || d1 !== '0 || d2 !== '0 || d3 !== '0) begin
         failures++;
         $display("FAIL rst_midframe: out_valid=%0b d1=%h d2=%h d3=%h, required 0 0 0 0", out_valid, d1, d2, d3);
      end
      f = rand_frame(NB);
      e = model(f);
      send_frame(f, 0);
      checks++;
      if (out_valid !== 1'b1 || {d1, d2, d3} !== e) begin
         failures++;
         $display("FAIL rst_after_mid: out_valid=%0b data=%h, required 1 %h", out_valid, {d1, d2, d3}, e);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || d1 !== '0 || d2 !== '0 || d3 !== '0) begin
         failures++;
         $display("FAIL rst_hold: out_valid=%0b d1=%h d2=%h d3=%h, required 0 0 0 0", out_valid, d1, d2, d3);
      end
      out_ready = 1'b1;
      f = rand_frame(NB);
      e = model(f);
      send_frame(f, 0);
      checks++;
      if (out_valid !== 1'b1 || {d1, d2, d3} !== e) begin
         failures++;
         $display("FAIL rst_fresh: out_valid=%0b data=%h, required 1 %h", out_valid, {d1, d2, d3}, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      fr_t expq[$];
      int  bad, errs, idle, cyc;
      bit  drv_done;
      bad = 0; errs = 0; idle = 0; cyc = 0; drv_done = 0;
      fork
         begin
            for (int fr = 0; fr < 1000; fr++) begin
               bq_t f;
               int kind, len;
               kind = int'($urandom % 10);
               if (kind < 8)       len = NB;
               else if (kind == 8) len = int'($urandom_range(1, NB - 1));
               else                len = int'($urandom_range(NB + 1, NB + 4));
               f = rand_frame(len);
               if (len == NB) expq.push_back(model(f));
               else bad++;
               send_frame(f, 1);
            end
            drv_done = 1;
         end
         begin
            fr_t prev, e;
            bit  prev_hold;
            prev_hold = 0; prev = '0;
            while (!(drv_done && expq.size() == 0 && idle >= 20) && cyc < 80000) begin
               @(negedge clk);
               cyc++;
               if (err) errs++;
               if (prev_hold) begin
                  checks++;
                  if (out_valid !== 1'b1 || {d1, d2, d3} !== prev) begin
                     failures++;
                     $display("FAIL rand_hold_stable: out_valid=%0b data=%h, required 1 %h", out_valid, {d1, d2, d3}, prev);
                  end
               end
               if (out_valid && out_ready) begin
                  checks++;
                  if (expq.size() == 0) begin
                     failures++;
                     $display("FAIL rand_dup: unexpected frame %h, required none pending", {d1, d2, d3});
                  end else begin
                     e = expq.pop_front();
                     if ({d1, d2, d3} !== e) begin
                        failures++;
                        $display("FAIL rand_frame: data=%h, required %h", {d1, d2, d3}, e);
                     end
                  end
               end
               prev_hold = out_valid && !out_ready;
               prev = {d1, d2, d3};
               if (drv_done) idle++;
               @(posedge clk); #1;
               out_ready = 1'($urandom);
            end
         end
      join
      checks++;
      if (cyc >= 80000 || expq.size() != 0) begin
         failures++;
         $display("FAIL rand_lost: pending=%0d cycles=%0d, required 0 pending", expq.size(), cyc);
      end
      checks++;
      if (errs != bad) begin
         failures++;
         $display("FAIL rand_err_count: err pulses=%0d, required %0d", errs, bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_short();
      test_long();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
